reservation_station: RTL and testbench

- Receiving end of the dispatch-to-RS interface in the Tomasulo core.
- Holds non-memory instructions until both operands are available.
  - Snoops both CDB ports (ALU result and LSB result) to wake up waiting operands.
  - Selects one ready entry per cycle and issues it, registered, to the ALU.
- Raises a full flag back to instruction fetch. Flushes completely on ROB mispredict.

---
 rtl/reservation_station_pkg.sv | 36 +++
 rtl/reservation_station_rs_select.sv | 38 +++
 rtl/reservation_station.sv | 223 ++++++++++++++++++++++
 tb/tb_reservation_station.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared constants for the reservation station: default widths, the
// NON_DEPENDENT tag sentinel and the ALU op-type encodings.
package reservation_station_pkg;

  localparam int RS_SIZE_DEF  = 16;
  localparam int ROB_ID_W_DEF = 5;
  localparam int DATA_W_DEF   = 32;
  localparam int OPE_W_DEF    = 6;

  // All-ones tag: the operand value is already valid.
  localparam logic [ROB_ID_W_DEF-1:0] NON_DEPENDENT = '1;

  typedef enum logic [OPE_W_DEF-1:0] {
    OP_ADD   = 6'd0,
    OP_SUB   = 6'd1,
    OP_AND   = 6'd2,
    OP_OR    = 6'd3,
    OP_XOR   = 6'd4,
    OP_SLL   = 6'd5,
    OP_SRL   = 6'd6,
    OP_SRA   = 6'd7,
    OP_SLT   = 6'd8,
    OP_SLTU  = 6'd9,
    OP_BEQ   = 6'd10,
    OP_BNE   = 6'd11,
    OP_BLT   = 6'd12,
    OP_BGE   = 6'd13,
    OP_BLTU  = 6'd14,
    OP_BGEU  = 6'd15,
    OP_LUI   = 6'd16,
    OP_AUIPC = 6'd17,
    OP_JAL   = 6'd18,
    OP_JALR  = 6'd19
  } op_type_e;

endpackage

// File: rtl/reservation_station_rs_select.sv
// Combinational slot picker: lowest free entry, lowest ready entry and the
// number of free entries, all from the registered busy/ready vectors.
module rs_select #(
  parameter int N = 16,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_busy,
  input  logic [N-1:0]  i_ready,
  output logic [IW-1:0] o_free_idx,
  output logic          o_free_vld,
  output logic [IW-1:0] o_ready_idx,
  output logic          o_ready_vld,
  output logic [IW:0]   o_free_cnt
);

  always_comb begin
    o_free_idx  = '0;
    o_free_vld  = 1'b0;
    o_ready_idx = '0;
    o_ready_vld = 1'b0;
    o_free_cnt  = '0;
    // Scanning downward leaves the lowest matching index in place.
    for (int i = N - 1; i >= 0; i--) begin
      if (!i_busy[i]) begin
        o_free_idx = IW'(i);
        o_free_vld = 1'b1;
      end
      if (i_ready[i]) begin
        o_ready_idx = IW'(i);
        o_ready_vld = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      o_free_cnt = o_free_cnt + {{IW{1'b0}}, ~i_busy[i]};
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: holds dispatched ops until both operands are
// valid, snoops both CDB ports, and issues one ready op per cycle to the ALU.
// Optional same-edge bypass of a ready dispatch is enabled by RS_BYPASS_EN.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE  = RS_SIZE_DEF,
  parameter int ROB_ID_W = ROB_ID_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int OPE_W    = OPE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                mispredict,
  input  logic                enable_from_dispatcher,
  input  logic [OPE_W-1:0]    type_from_dispatcher,
  input  logic [DATA_W-1:0]   Vj_from_dispatcher,
  input  logic [DATA_W-1:0]   Vk_from_dispatcher,
  input  logic [ROB_ID_W-1:0] Qj_from_dispatcher,
  input  logic [ROB_ID_W-1:0] Qk_from_dispatcher,
  input  logic [DATA_W-1:0]   imm_from_dispatcher,
  input  logic [DATA_W-1:0]   pc_from_dispatcher,
  input  logic [ROB_ID_W-1:0] rob_id_from_dispatcher,
  input  logic                enable_cdb_rs,
  input  logic [ROB_ID_W-1:0] cdb_rs_rob_id,
  input  logic [DATA_W-1:0]   cdb_rs_value,
  input  logic                enable_cdb_lsb,
  input  logic [ROB_ID_W-1:0] cdb_lsb_rob_id,
  input  logic [DATA_W-1:0]   cdb_lsb_value,
  output logic                full_to_if,
  output logic                enable_to_alu,
  output logic [OPE_W-1:0]    type_to_alu,
  output logic [DATA_W-1:0]   Vj_to_alu,
  output logic [DATA_W-1:0]   Vk_to_alu,
  output logic [DATA_W-1:0]   imm_to_alu,
  output logic [DATA_W-1:0]   pc_to_alu,
  output logic [ROB_ID_W-1:0] rob_id_to_alu
);

  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = IW + 1;
  localparam logic [ROB_ID_W-1:0] TAG_ND = '1;

  logic [RS_SIZE-1:0]  r_busy;
  logic [OPE_W-1:0]    r_type [RS_SIZE];
  logic [DATA_W-1:0]   r_vj   [RS_SIZE];
  logic [DATA_W-1:0]   r_vk   [RS_SIZE];
  logic [ROB_ID_W-1:0] r_qj   [RS_SIZE];
  logic [ROB_ID_W-1:0] r_qk   [RS_SIZE];
  logic [DATA_W-1:0]   r_imm  [RS_SIZE];
  logic [DATA_W-1:0]   r_pc   [RS_SIZE];
  logic [ROB_ID_W-1:0] r_rob  [RS_SIZE];

  logic                r_enable_to_alu;
  logic [OPE_W-1:0]    r_type_to_alu;
  logic [DATA_W-1:0]   r_vj_to_alu;
  logic [DATA_W-1:0]   r_vk_to_alu;
  logic [DATA_W-1:0]   r_imm_to_alu;
  logic [DATA_W-1:0]   r_pc_to_alu;
  logic [ROB_ID_W-1:0] r_rob_to_alu;

  logic [RS_SIZE-1:0]  w_ready;
  logic [IW-1:0]       w_free_idx;
  logic                w_free_vld;
  logic [IW-1:0]       w_ready_idx;
  logic                w_ready_vld;
  logic [CW-1:0]       w_free_cnt;
  logic [DATA_W-1:0]   w_d_vj;
  logic [DATA_W-1:0]   w_d_vk;
  logic [ROB_ID_W-1:0] w_d_qj;
  logic [ROB_ID_W-1:0] w_d_qk;
  logic                w_bypass;

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_ready[i] = r_busy[i] && (r_qj[i] == TAG_ND) && (r_qk[i] == TAG_ND);
    end
  end

  rs_select #(.N(RS_SIZE)) u_select (
    .i_busy      (r_busy),
    .i_ready     (w_ready),
    .o_free_idx  (w_free_idx),
    .o_free_vld  (w_free_vld),
    .o_ready_idx (w_ready_idx),
    .o_ready_vld (w_ready_vld),
    .o_free_cnt  (w_free_cnt)
  );

  // One spare slot covers the dispatch already in flight behind the stall.
  assign full_to_if = (w_free_cnt < CW'(2));

  // Incoming operands snoop the CDB the same cycle; the LSB port wins.
  always_comb begin
    w_d_vj = Vj_from_dispatcher;
    w_d_qj = Qj_from_dispatcher;
    w_d_vk = Vk_from_dispatcher;
    w_d_qk = Qk_from_dispatcher;
    if (Qj_from_dispatcher != TAG_ND) begin
      if (enable_cdb_lsb && (cdb_lsb_rob_id == Qj_from_dispatcher)) begin
        w_d_vj = cdb_lsb_value;
        w_d_qj = TAG_ND;
      end else if (enable_cdb_rs && (cdb_rs_rob_id == Qj_from_dispatcher)) begin
        w_d_vj = cdb_rs_value;
        w_d_qj = TAG_ND;
      end
    end
    if (Qk_from_dispatcher != TAG_ND) begin
      if (enable_cdb_lsb && (cdb_lsb_rob_id == Qk_from_dispatcher)) begin
        w_d_vk = cdb_lsb_value;
        w_d_qk = TAG_ND;
      end else if (enable_cdb_rs && (cdb_rs_rob_id == Qk_from_dispatcher)) begin
        w_d_vk = cdb_rs_value;
        w_d_qk = TAG_ND;
      end
    end
  end

`ifdef RS_BYPASS_EN
  assign w_bypass = enable_from_dispatcher && (w_d_qj == TAG_ND) &&
                    (w_d_qk == TAG_ND) && !w_ready_vld;
`else
  assign w_bypass = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy          <= '0;
      r_enable_to_alu <= 1'b0;
      r_type_to_alu   <= '0;
      r_vj_to_alu     <= '0;
      r_vk_to_alu     <= '0;
      r_imm_to_alu    <= '0;
      r_pc_to_alu     <= '0;
      r_rob_to_alu    <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_type[i] <= '0;
        r_vj[i]   <= '0;
        r_vk[i]   <= '0;
        r_qj[i]   <= '0;
        r_qk[i]   <= '0;
        r_imm[i]  <= '0;
        r_pc[i]   <= '0;
        r_rob[i]  <= '0;
      end
    end else if (mispredict) begin
      r_busy          <= '0;
      r_enable_to_alu <= 1'b0;
    end else if (rdy) begin
      // Later assignments win, so the LSB port overrides the ALU port.
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i] && (r_qj[i] != TAG_ND)) begin
          if (enable_cdb_rs && (cdb_rs_rob_id == r_qj[i])) begin
            r_vj[i] <= cdb_rs_value;
            r_qj[i] <= TAG_ND;
          end
          if (enable_cdb_lsb && (cdb_lsb_rob_id == r_qj[i])) begin
            r_vj[i] <= cdb_lsb_value;
            r_qj[i] <= TAG_ND;
          end
        end
        if (r_busy[i] && (r_qk[i] != TAG_ND)) begin
          if (enable_cdb_rs && (cdb_rs_rob_id == r_qk[i])) begin
            r_vk[i] <= cdb_rs_value;
            r_qk[i] <= TAG_ND;
          end
          if (enable_cdb_lsb && (cdb_lsb_rob_id == r_qk[i])) begin
            r_vk[i] <= cdb_lsb_value;
            r_qk[i] <= TAG_ND;
          end
        end
      end

      if (w_ready_vld) begin
        r_enable_to_alu     <= 1'b1;
        r_type_to_alu       <= r_type[w_ready_idx];
        r_vj_to_alu         <= r_vj[w_ready_idx];
        r_vk_to_alu         <= r_vk[w_ready_idx];
        r_imm_to_alu        <= r_imm[w_ready_idx];
        r_pc_to_alu         <= r_pc[w_ready_idx];
        r_rob_to_alu        <= r_rob[w_ready_idx];
        r_busy[w_ready_idx] <= 1'b0;
      end else if (w_bypass) begin
        r_enable_to_alu <= 1'b1;
        r_type_to_alu   <= type_from_dispatcher;
        r_vj_to_alu     <= w_d_vj;
        r_vk_to_alu     <= w_d_vk;
        r_imm_to_alu    <= imm_from_dispatcher;
        r_pc_to_alu     <= pc_from_dispatcher;
        r_rob_to_alu    <= rob_id_from_dispatcher;
      end else begin
        r_enable_to_alu <= 1'b0;
      end

      if (enable_from_dispatcher && w_free_vld && !w_bypass) begin
        r_busy[w_free_idx] <= 1'b1;
        r_type[w_free_idx] <= type_from_dispatcher;
        r_vj[w_free_idx]   <= w_d_vj;
        r_vk[w_free_idx]   <= w_d_vk;
        r_qj[w_free_idx]   <= w_d_qj;
        r_qk[w_free_idx]   <= w_d_qk;
        r_imm[w_free_idx]  <= imm_from_dispatcher;
        r_pc[w_free_idx]   <= pc_from_dispatcher;
        r_rob[w_free_idx]  <= rob_id_from_dispatcher;
      end
    end
  end

  assign enable_to_alu = r_enable_to_alu;
  assign type_to_alu   = r_type_to_alu;
  assign Vj_to_alu     = r_vj_to_alu;
  assign Vk_to_alu     = r_vk_to_alu;
  assign imm_to_alu    = r_imm_to_alu;
  assign pc_to_alu     = r_pc_to_alu;
  assign rob_id_to_alu = r_rob_to_alu;

  // Dispatch into a full station is a protocol error on the dispatcher side.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (rdy && !mispredict && enable_from_dispatcher && !w_bypass) |-> w_free_vld);

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: a slot-level reference model
// predicts every ALU issue; a negedge monitor pops and compares.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int N  = 16;
  localparam int RW = 5;
  localparam int DW = 32;
  localparam int OW = 6;
  localparam logic [RW-1:0] ND = NON_DEPENDENT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic mispredict = 1'b0;
  logic enable_from_dispatcher = 1'b0;
  logic [OW-1:0] type_from_dispatcher = '0;
  logic [DW-1:0] Vj_from_dispatcher = '0, Vk_from_dispatcher = '0;
  logic [RW-1:0] Qj_from_dispatcher = '1, Qk_from_dispatcher = '1;
  logic [DW-1:0] imm_from_dispatcher = '0, pc_from_dispatcher = '0;
  logic [RW-1:0] rob_id_from_dispatcher = '0;
  logic enable_cdb_rs = 1'b0, enable_cdb_lsb = 1'b0;
  logic [RW-1:0] cdb_rs_rob_id = '0, cdb_lsb_rob_id = '0;
  logic [DW-1:0] cdb_rs_value = '0, cdb_lsb_value = '0;
  logic full_to_if, enable_to_alu;
  logic [OW-1:0] type_to_alu;
  logic [DW-1:0] Vj_to_alu, Vk_to_alu, imm_to_alu, pc_to_alu;
  logic [RW-1:0] rob_id_to_alu;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mispredict(mispredict),
    .enable_from_dispatcher(enable_from_dispatcher),
    .type_from_dispatcher(type_from_dispatcher),
    .Vj_from_dispatcher(Vj_from_dispatcher), .Vk_from_dispatcher(Vk_from_dispatcher),
    .Qj_from_dispatcher(Qj_from_dispatcher), .Qk_from_dispatcher(Qk_from_dispatcher),
    .imm_from_dispatcher(imm_from_dispatcher), .pc_from_dispatcher(pc_from_dispatcher),
    .rob_id_from_dispatcher(rob_id_from_dispatcher),
    .enable_cdb_rs(enable_cdb_rs), .enable_cdb_lsb(enable_cdb_lsb),
    .cdb_rs_rob_id(cdb_rs_rob_id), .cdb_lsb_rob_id(cdb_lsb_rob_id),
    .cdb_rs_value(cdb_rs_value), .cdb_lsb_value(cdb_lsb_value),
    .full_to_if(full_to_if), .enable_to_alu(enable_to_alu),
    .type_to_alu(type_to_alu), .Vj_to_alu(Vj_to_alu), .Vk_to_alu(Vk_to_alu),
    .imm_to_alu(imm_to_alu), .pc_to_alu(pc_to_alu), .rob_id_to_alu(rob_id_to_alu)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] typ;
    logic [DW-1:0] vj, vk, imm, pc;
    logic [RW-1:0] qj, qk, rob;
  } ins_t;

  typedef struct {
    int   cyc;
    ins_t ins;
  } iss_t;

  iss_t exp_q[$];
  ins_t m_ent[N];
  bit   m_busy[N];
  ins_t m_last;
  bit   m_en = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  function automatic int m_free();
    int n = 0;
    for (int i = 0; i < N; i++) if (!m_busy[i]) n++;
    return n;
  endfunction

  // An operand waiting on a tag takes the broadcast value; LSB beats ALU.
  function automatic void resolve(inout logic [RW-1:0] q, inout logic [DW-1:0] v);
    if (q == ND) return;
    if (enable_cdb_lsb && cdb_lsb_rob_id == q) begin
      v = cdb_lsb_value; q = ND;
    end else if (enable_cdb_rs && cdb_rs_rob_id == q) begin
      v = cdb_rs_value; q = ND;
    end
  endfunction

  initial begin
    m_last = '{default: '0};
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b0;
      m_ent[i]  = '{default: '0};
    end
  end

  // Reference model: evaluated once per clock from the pre-edge inputs.
  always @(posedge clk) begin
    int   sel;
    int   fr;
    bit   byp;
    ins_t d;
    cyc++;
    sel = -1;
    fr  = -1;
    byp = 1'b0;
    if (rst) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_last = '{default: '0};
      m_en   = 1'b0;
    end else if (mispredict) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_en = 1'b0;
    end else if (!rdy) begin
      if (m_en) exp_q.push_back('{cyc, m_last});
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (m_busy[i] && m_ent[i].qj == ND && m_ent[i].qk == ND) sel = i;
        if (!m_busy[i]) fr = i;
      end
      d.typ = type_from_dispatcher;
      d.vj  = Vj_from_dispatcher;  d.qj = Qj_from_dispatcher;
      d.vk  = Vk_from_dispatcher;  d.qk = Qk_from_dispatcher;
      d.imm = imm_from_dispatcher; d.pc = pc_from_dispatcher;
      d.rob = rob_id_from_dispatcher;
      resolve(d.qj, d.vj);
      resolve(d.qk, d.vk);
`ifdef RS_BYPASS_EN
      byp = enable_from_dispatcher && d.qj == ND && d.qk == ND && sel < 0;
`endif
      if (sel >= 0) begin
        m_last = m_ent[sel];
        m_busy[sel] = 1'b0;
        m_en = 1'b1;
      end else if (byp) begin
        m_last = d;
        m_en = 1'b1;
      end else begin
        m_en = 1'b0;
      end
      if (m_en) exp_q.push_back('{cyc, m_last});
      for (int i = 0; i < N; i++) begin
        if (m_busy[i]) begin
          resolve(m_ent[i].qj, m_ent[i].vj);
          resolve(m_ent[i].qk, m_ent[i].vk);
        end
      end
      if (enable_from_dispatcher && !byp && fr >= 0) begin
        m_ent[fr]  = d;
        m_busy[fr] = 1'b1;
      end
    end
  end

  function automatic bit out_matches(ins_t e);
    return type_to_alu == e.typ && Vj_to_alu == e.vj && Vk_to_alu == e.vk &&
           imm_to_alu == e.imm && pc_to_alu == e.pc && rob_id_to_alu == e.rob;
  endfunction

  // Monitor: compares outputs against the scoreboard away from the clock edge.
  always @(negedge clk) begin
    iss_t e;
    checks++;
    if (full_to_if !== (m_free() <= 1)) begin
      errors++;
      $display("FAIL full cyc=%0d got=%0b exp=%0b", cyc, full_to_if, (m_free() <= 1));
    end
    checks++;
    if (enable_to_alu === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue cyc=%0d got rob=%0d exp no issue", cyc, rob_id_to_alu);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || !out_matches(e.ins)) begin
          errors++;
          $display("FAIL issue cyc=%0d got rob=%0d typ=%0d vj=%h vk=%h imm=%h pc=%h exp cyc=%0d rob=%0d typ=%0d vj=%h vk=%h imm=%h pc=%h",
                   cyc, rob_id_to_alu, type_to_alu, Vj_to_alu, Vk_to_alu, imm_to_alu, pc_to_alu,
                   e.cyc, e.ins.rob, e.ins.typ, e.ins.vj, e.ins.vk, e.ins.imm, e.ins.pc);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      errors++;
      $display("FAIL missed_issue cyc=%0d got enable=%b exp rob=%0d at cyc=%0d",
               cyc, enable_to_alu, e.ins.rob, e.cyc);
    end else if (!out_matches(m_last)) begin
      errors++;
      $display("FAIL hold cyc=%0d got rob=%0d vj=%h vk=%h exp rob=%0d vj=%h vk=%h",
               cyc, rob_id_to_alu, Vj_to_alu, Vk_to_alu, m_last.rob, m_last.vj, m_last.vk);
    end
  end

  task automatic step();
    @(negedge clk);
    enable_from_dispatcher = 1'b0;
    enable_cdb_rs  = 1'b0;
    enable_cdb_lsb = 1'b0;
    mispredict = 1'b0;
    rdy = 1'b1;
  endtask

  task automatic disp(input logic [OW-1:0] t, input logic [DW-1:0] vj, input logic [DW-1:0] vk,
                      input logic [RW-1:0] qj, input logic [RW-1:0] qk, input logic [RW-1:0] rob);
    enable_from_dispatcher = 1'b1;
    type_from_dispatcher = t;
    Vj_from_dispatcher = vj;
    Vk_from_dispatcher = vk;
    Qj_from_dispatcher = qj;
    Qk_from_dispatcher = qk;
    imm_from_dispatcher = $urandom;
    pc_from_dispatcher = $urandom;
    rob_id_from_dispatcher = rob;
  endtask

  task automatic cdb_rs(input logic [RW-1:0] tag, input logic [DW-1:0] val);
    enable_cdb_rs = 1'b1; cdb_rs_rob_id = tag; cdb_rs_value = val;
  endtask

  task automatic cdb_lsb(input logic [RW-1:0] tag, input logic [DW-1:0] val);
    enable_cdb_lsb = 1'b1; cdb_lsb_rob_id = tag; cdb_lsb_value = val;
  endtask

  function automatic logic [RW-1:0] rnd_tag();
    logic [RW-1:0] t;
    t = ($urandom_range(0, 2) == 0) ? ND : RW'($urandom_range(0, 7));
    return t;
  endfunction

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step(); step();

    // Ready ADD issues one edge after being written.
    step(); disp(OP_ADD, 32'd5, 32'd7, ND, ND, 5'd3);
    repeat (3) step();

    // Qj waits on tag 2 until the ALU CDB delivers 0x10.
    step(); disp(OP_SUB, 32'd0, 32'd1, 5'd2, ND, 5'd4);
    step(); step();
    step(); cdb_rs(5'd2, 32'h10);
    repeat (3) step();

    // Qk resolved by the LSB CDB during dispatch itself.
    step(); disp(OP_XOR, 32'd1, 32'd0, ND, 5'd4, 5'd6); cdb_lsb(5'd4, 32'd9);
    repeat (3) step();

    // Both ports broadcast the same tag: LSB value must be stored.
    step(); disp(OP_OR, 32'd0, 32'd0, 5'd1, 5'd1, 5'd8); cdb_rs(5'd1, 32'haaaa); cdb_lsb(5'd1, 32'h5555);
    repeat (3) step();

    // Fill until full, all waiting on tag 7, then release in index order.
    for (int i = 0; i < N; i++) begin
      step();
      if (m_free() > 1) disp(OP_AND, $urandom, $urandom, 5'd7, ND, RW'(i));
    end
    step();
    step(); cdb_rs(5'd7, 32'h77);
    repeat (20) step();

    // Mispredict wipes four waiting entries and the concurrent dispatch.
    for (int i = 0; i < 4; i++) begin
      step(); disp(OP_SLT, $urandom, $urandom, 5'd6, ND, RW'(10 + i));
    end
    step(); mispredict = 1'b1; disp(OP_ADD, 32'd1, 32'd2, ND, ND, 5'd20);
    step(); cdb_rs(5'd6, 32'h66);
    repeat (3) step();

    // Freeze for three cycles with a ready entry and a CDB broadcast.
    step(); disp(OP_SLL, 32'd3, 32'd4, ND, ND, 5'd21);
    step(); rdy = 1'b0; disp(OP_SRL, 32'd0, 32'd4, 5'd5, ND, 5'd22);
    step(); rdy = 1'b0; cdb_rs(5'd5, 32'h55);
    step(); rdy = 1'b0;
    repeat (4) step();
    step(); cdb_lsb(5'd5, 32'h56);
    repeat (3) step();

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      step();
      rdy = ($urandom_range(0, 19) != 0);
      mispredict = ($urandom_range(0, 99) == 0);
      if (m_free() > 1 && $urandom_range(0, 1) == 1)
        disp(OP_TYPE_RND(), $urandom, $urandom, rnd_tag(), rnd_tag(), RW'($urandom_range(0, 30)));
      if ($urandom_range(0, 2) == 0) cdb_rs(RW'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 2) == 0) cdb_lsb(RW'($urandom_range(0, 7)), $urandom);
    end

    // Drain: broadcast every tag so all waiting entries can issue.
    for (int r = 0; r < 3; r++) begin
      for (int t = 0; t < 8; t++) begin
        step(); cdb_rs(RW'(t), $urandom);
      end
    end
    repeat (25) step();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d exp pending=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [OW-1:0] OP_TYPE_RND();
    logic [OW-1:0] t;
    t = OW'($urandom_range(0, 19));
    return t;
  endfunction

endmodule
